nf10_axi_lite_ipif_bridge: RTL and testbench
============================================

// Module: nf10_axi_lite_ipif_bridge
// PURPOSE
//  Single-BAR AXI4-Lite slave to IPIF bridge; sits directly upstream of register/ROM blocks (e.g. nf10_identifier)
//  and drives their Bus2IP_* / IP2Bus_* interface. Accepts one transaction at a time, decodes the BAR and issues
//  one IPIF data phase. Returns the AXI response, with data-phase timeout and error mapping.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32            data width (32 only)
//  C_S_AXI_ADDR_WIDTH  32            address width
//  C_BASEADDR          32'hFFFFFFFF  BAR low address, inclusive
//  C_HIGHADDR          32'h00000000  BAR high address, inclusive
//  C_USE_WSTRB         0             1: Bus2IP_BE=WSTRB on writes; 0: all ones
//  C_DPHASE_TIMEOUT    8             cycles waiting for ack before forced SLVERR; 0 disables timeout
// PORTS
//  S_AXI_ACLK      in   1      clock; one clock domain
//  S_AXI_ARESET    in   1      reset, synchronous, active-high
//  S_AXI_AWADDR/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP[1:0]/BVALID/BREADY   AXI4-Lite write channels
//  S_AXI_ARADDR/ARVALID/ARREADY, RDATA/RRESP[1:0]/RVALID/RREADY                       AXI4-Lite read channels
//  Bus2IP_Clk      out  1      = S_AXI_ACLK
//  Bus2IP_Resetn   out  1      = ~S_AXI_ARESET
//  Bus2IP_Addr     out  ADDR   latched transaction address
//  Bus2IP_CS       out  1      data phase active
//  Bus2IP_RNW      out  1      1 read, 0 write
//  Bus2IP_Data     out  DATA   latched WDATA
//  Bus2IP_BE       out  DATA/8 byte enables (all ones on reads)
//  IP2Bus_Data     in   DATA   read data, valid with IP2Bus_RdAck
//  IP2Bus_RdAck    in   1      read ack
//  IP2Bus_WrAck    in   1      write ack
//  IP2Bus_Error    in   1      error, sampled with either ack
// BEHAVIOUR
//  Reset: all AXI ready/valid, BRESP, RRESP, RDATA, Bus2IP_CS/Addr/Data/BE = 0, RNW=1; state IDLE, priority=read.
//  Reset has effect in any state: in-flight transaction dropped, no response issued.
//  FSM states: IDLE -> (RD_PHASE | WR_PHASE) -> (R_RESP | B_RESP) -> IDLE.
//  IDLE, cycle N: read candidate = ARVALID. Write candidate = AWVALID&WVALID (both required; AW alone waits).
//   Both candidates: round-robin, favour the type not served last. Latch addr (and WDATA/BE) at N.
//  Cycle N+1: one-cycle ARREADY pulse (or AWREADY+WREADY together) completes the handshake.
//   If in BAR: Bus2IP_CS=1, RNW set; enter *_PHASE. If out of BAR: no CS, go straight to *_RESP with DECERR (2'b11), RDATA=0.
//  *_PHASE: CS held until first matching ack (RdAck when RNW=1, WrAck when RNW=0; the other ack is ignored).
//   Ack seen at cycle M: capture IP2Bus_Data (reads); RESP = Error ? SLVERR(2'b10) : OKAY(2'b00).
//   At M+1: CS=0, RVALID/BVALID=1. Later acks while CS falls are ignored; slaves may hold ack while CS high.
//  Timeout: counter clears on phase entry and increments each phase cycle. If C_DPHASE_TIMEOUT>0 and count reaches it with no ack:
//   end phase, SLVERR, RDATA=0. An ack in the same cycle as expiry wins (normal response).
//  *_RESP: RVALID/BVALID and RDATA/RRESP/BRESP held stable until RREADY/BREADY; cleared the cycle after the handshake, return IDLE.
//   A new transaction may be accepted in IDLE on the next cycle.
//  Latency, in-BAR read with a single-cycle-ack slave: ARVALID@N, ARREADY@N+1, RdAck@N+2, RVALID@N+3.
//  BAR check: C_BASEADDR <= addr <= C_HIGHADDR, unsigned, full width. Bus2IP_Addr passes the full address (slave takes low bits).
//  Never more than one outstanding transaction; CS and a response valid are never high together.
// TESTING
//  1 BAR 0x7A000000-0x7A00FFFF, slave = nf10_identifier ROM word2=0xCAFE0002; read 0x7A000008
//    -> ARREADY@N+1, CS@N+1..N+2, RVALID@N+3, RDATA=0xCAFE0002, RRESP=00.
//  2 Write 0x7A000004 data 0x12345678, WSTRB=4'b0011, C_USE_WSTRB=1 -> Bus2IP_Data=0x12345678, BE=0011; BVALID one cycle after WrAck, BRESP=00.
//  3 Read 0x7B000000 (outside BAR) -> CS never asserted, RVALID@N+2, RRESP=11, RDATA=0; write outside BAR -> BRESP=11.
//  4 Slave never acks, C_DPHASE_TIMEOUT=8 -> CS low after 8 phase cycles, RRESP=10, RDATA=0. Ack with IP2Bus_Error=1 -> resp 10.
//  5 ARVALID and AWVALID+WVALID high together for 4 transactions -> served R,W,R,W. Hold RREADY low 5 cycles -> RVALID/RDATA stable, no new ARREADY.
//  6 Assert S_AXI_ARESET during RD_PHASE -> next cycle CS=0, RVALID=0, state IDLE; a fresh read afterwards completes normally.

Source files
------------

// File: rtl/nf10_axi_lite_ipif_bridge_if.sv
// Signal bundle between an AXI4-Lite master, the AXI-Lite-to-IPIF bridge and the IPIF register slave.
// AXI channels: a beat transfers on the rising edge where VALID and READY are both high; VALID,
// once raised, holds its payload stable until that edge, and READY may not be waited on by VALID.
interface nf10_axi_lite_ipif_bridge_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  logic                            Bus2IP_Clk;
  logic                            Bus2IP_Resetn;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   Bus2IP_Addr;
  logic                            Bus2IP_CS;
  logic                            Bus2IP_RNW;
  logic [C_S_AXI_DATA_WIDTH-1:0]   Bus2IP_Data;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] Bus2IP_BE;
  logic [C_S_AXI_DATA_WIDTH-1:0]   IP2Bus_Data;
  logic                            IP2Bus_RdAck;
  logic                            IP2Bus_WrAck;
  logic                            IP2Bus_Error;

  // Bridge side: AXI slave toward the master, IPIF master toward the register block.
  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output Bus2IP_Clk, Bus2IP_Resetn, Bus2IP_Addr, Bus2IP_CS, Bus2IP_RNW, Bus2IP_Data, Bus2IP_BE,
    input  IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );

  // Environment side: AXI master plus the IPIF register slave.
  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  Bus2IP_Clk, Bus2IP_Resetn, Bus2IP_Addr, Bus2IP_CS, Bus2IP_RNW, Bus2IP_Data, Bus2IP_BE,
    output IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );
endinterface

// File: rtl/nf10_axi_lite_ipif_bridge.sv
// Single-BAR AXI4-Lite slave to IPIF bridge: one transaction at a time, one IPIF data phase each,
// with decode error outside the BAR and a data-phase timeout that forces SLVERR.
module nf10_axi_lite_ipif_bridge #(
  parameter int                            C_S_AXI_DATA_WIDTH = 32,
  parameter int                            C_S_AXI_ADDR_WIDTH = 32,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASEADDR         = {C_S_AXI_ADDR_WIDTH{1'b1}},
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_HIGHADDR         = '0,
  parameter int                            C_USE_WSTRB        = 0,
  parameter int                            C_DPHASE_TIMEOUT   = 8
) (
  input  logic                       S_AXI_ACLK,
  input  logic                       S_AXI_ARESET,
  nf10_axi_lite_ipif_bridge_if.slave bus,
  output logic [2:0]                 dbg_state
);
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int BW = DW / 8;
  localparam logic [31:0] TO_LAST = 32'(C_DPHASE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_PHASE = 3'd1,
    ST_WR_PHASE = 3'd2,
    ST_R_RESP   = 3'd3,
    ST_B_RESP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            arready_q, arready_d;
  logic            awready_q, awready_d;
  logic            cs_q, cs_d;
  logic            rnw_q, rnw_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [BW-1:0]   be_q, be_d;
  logic            rvalid_q, rvalid_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;
  logic            bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            last_rd_q, last_rd_d;

  logic            rd_cand, wr_cand, pick_rd, pick_wr;
  logic [AW-1:0]   sel_addr;
  logic            sel_in_bar;
  logic            ack_hit, timeout_hit, phase_done;
  logic [1:0]      phase_resp;

  // Round-robin: a read wins a tie unless the previous served transaction was a read.
  assign rd_cand    = bus.S_AXI_ARVALID;
  assign wr_cand    = bus.S_AXI_AWVALID & bus.S_AXI_WVALID;
  assign pick_rd    = rd_cand & (~wr_cand | ~last_rd_q);
  assign pick_wr    = wr_cand & ~pick_rd;
  assign sel_addr   = pick_rd ? bus.S_AXI_ARADDR : bus.S_AXI_AWADDR;
  assign sel_in_bar = (sel_addr >= C_BASEADDR) && (sel_addr <= C_HIGHADDR);

  // In a phase state, CS low means the address missed the BAR and the phase is skipped.
  assign ack_hit     = cs_q & (rnw_q ? bus.IP2Bus_RdAck : bus.IP2Bus_WrAck);
  assign timeout_hit = cs_q && (C_DPHASE_TIMEOUT > 0) && (cnt_q == TO_LAST);
  assign phase_done  = ~cs_q | ack_hit | timeout_hit;
  assign phase_resp  = ~cs_q   ? 2'b11 :
                       ack_hit ? (bus.IP2Bus_Error ? 2'b10 : 2'b00) :
                                 2'b10;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q   <= ST_IDLE;
      arready_q <= 1'b0;
      awready_q <= 1'b0;
      cs_q      <= 1'b0;
      rnw_q     <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      cnt_q     <= '0;
      last_rd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      awready_q <= awready_d;
      cs_q      <= cs_d;
      rnw_q     <= rnw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      cnt_q     <= cnt_d;
      last_rd_q <= last_rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_rd)      state_d = ST_RD_PHASE;
        else if (pick_wr) state_d = ST_WR_PHASE;
      end
      ST_RD_PHASE: if (phase_done)          state_d = ST_R_RESP;
      ST_WR_PHASE: if (phase_done)          state_d = ST_B_RESP;
      ST_R_RESP:   if (bus.S_AXI_RREADY)    state_d = ST_IDLE;
      ST_B_RESP:   if (bus.S_AXI_BREADY)    state_d = ST_IDLE;
      default:                              state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    arready_d = 1'b0;
    awready_d = 1'b0;
    cs_d      = cs_q;
    rnw_d     = rnw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    cnt_d     = cnt_q;
    last_rd_d = last_rd_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_rd || pick_wr) begin
          addr_d    = sel_addr;
          rnw_d     = pick_rd;
          cs_d      = sel_in_bar;
          cnt_d     = '0;
          last_rd_d = pick_rd;
          arready_d = pick_rd;
          awready_d = pick_wr;
          be_d      = '1;
          if (pick_wr) begin
            wdata_d = bus.S_AXI_WDATA;
            if (C_USE_WSTRB != 0) be_d = bus.S_AXI_WSTRB;
          end
        end
      end
      ST_RD_PHASE, ST_WR_PHASE: begin
        if (phase_done) begin
          cs_d = 1'b0;
          if (state_q == ST_RD_PHASE) begin
            rvalid_d = 1'b1;
            rresp_d  = phase_resp;
            rdata_d  = ack_hit ? bus.IP2Bus_Data : '0;
          end else begin
            bvalid_d = 1'b1;
            bresp_d  = phase_resp;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_R_RESP: begin
        if (bus.S_AXI_RREADY) begin
          rvalid_d = 1'b0;
          rdata_d  = '0;
          rresp_d  = 2'b00;
        end
      end
      ST_B_RESP: begin
        if (bus.S_AXI_BREADY) begin
          bvalid_d = 1'b0;
          bresp_d  = 2'b00;
        end
      end
      default: ;
    endcase
  end

  assign bus.S_AXI_ARREADY = arready_q;
  assign bus.S_AXI_AWREADY = awready_q;
  assign bus.S_AXI_WREADY  = awready_q;
  assign bus.S_AXI_RVALID  = rvalid_q;
  assign bus.S_AXI_RDATA   = rdata_q;
  assign bus.S_AXI_RRESP   = rresp_q;
  assign bus.S_AXI_BVALID  = bvalid_q;
  assign bus.S_AXI_BRESP   = bresp_q;
  assign bus.Bus2IP_Clk    = S_AXI_ACLK;
  assign bus.Bus2IP_Resetn = ~S_AXI_ARESET;
  assign bus.Bus2IP_Addr   = addr_q;
  assign bus.Bus2IP_CS     = cs_q;
  assign bus.Bus2IP_RNW    = rnw_q;
  assign bus.Bus2IP_Data   = wdata_q;
  assign bus.Bus2IP_BE     = be_q;
  assign dbg_state         = state_q;
endmodule

// File: tb/tb_nf10_axi_lite_ipif_bridge.sv
// Directed bench for the AXI-Lite to IPIF bridge: BAR 0x7A000000-0x7A00FFFF, WSTRB passed through,
// 8-cycle data-phase timeout, with a small identifier-ROM slave whose ack behaviour is selectable.
module tb_nf10_axi_lite_ipif_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  dbg_state;
  int          n_vec = 0;
  int          n_err = 0;
  int          slave_mode = 0;   // 0 normal ack, 1 never ack, 2 ack with error
  logic [31:0] rom [4];
  logic [31:0] cap_data, cap_addr;
  logic [3:0]  cap_be;
  logic        sl_go;

  nf10_axi_lite_ipif_bridge_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(32)) bus_if ();

  nf10_axi_lite_ipif_bridge #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(32),
    .C_BASEADDR        (32'h7A000000),
    .C_HIGHADDR        (32'h7A00FFFF),
    .C_USE_WSTRB       (1),
    .C_DPHASE_TIMEOUT  (8)
  ) dut (
    .S_AXI_ACLK  (clk),
    .S_AXI_ARESET(rst),
    .bus         (bus_if),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // identifier ROM slave: registered single-cycle ack one cycle after it sees CS
  always @(posedge clk) begin
    if (rst) begin
      bus_if.IP2Bus_RdAck <= 1'b0;
      bus_if.IP2Bus_WrAck <= 1'b0;
      bus_if.IP2Bus_Error <= 1'b0;
      bus_if.IP2Bus_Data  <= '0;
    end else begin
      sl_go = bus_if.Bus2IP_CS && (slave_mode != 1) && !bus_if.IP2Bus_RdAck && !bus_if.IP2Bus_WrAck;
      bus_if.IP2Bus_RdAck <= sl_go && bus_if.Bus2IP_RNW;
      bus_if.IP2Bus_WrAck <= sl_go && !bus_if.Bus2IP_RNW;
      bus_if.IP2Bus_Error <= sl_go && (slave_mode == 2);
      bus_if.IP2Bus_Data  <= (sl_go && bus_if.Bus2IP_RNW) ? rom[bus_if.Bus2IP_Addr[3:2]] : 32'h0;
    end
  end

  always @(posedge clk) begin
    if (bus_if.Bus2IP_CS && !bus_if.Bus2IP_RNW) begin
      cap_data <= bus_if.Bus2IP_Data;
      cap_be   <= bus_if.Bus2IP_BE;
      cap_addr <= bus_if.Bus2IP_Addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                         input logic [1:0] exp_r, input int exp_lat, input int exp_cs);
    int n;
    int cs_n;
    bus_if.S_AXI_ARADDR  = a;
    bus_if.S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    n = 1;
    cs_n = 0;
    chk({tag, "_arready"}, 32'(bus_if.S_AXI_ARREADY), 32'd1);
    bus_if.S_AXI_ARVALID = 1'b0;
    while (!bus_if.S_AXI_RVALID && n < 40) begin
      if (bus_if.Bus2IP_CS) cs_n++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_cs_cycles"}, 32'(cs_n), 32'(exp_cs));
    chk({tag, "_rdata"}, bus_if.S_AXI_RDATA, exp_d);
    chk({tag, "_rresp"}, 32'(bus_if.S_AXI_RRESP), 32'(exp_r));
    bus_if.S_AXI_RREADY = 1'b1;
    @(negedge clk);
    chk({tag, "_rvalid_clr"}, 32'(bus_if.S_AXI_RVALID), 32'd0);
    bus_if.S_AXI_RREADY = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] exp_r, input int exp_lat,
                          input int exp_cs);
    int n;
    int cs_n;
    bus_if.S_AXI_AWADDR  = a;
    bus_if.S_AXI_WDATA   = d;
    bus_if.S_AXI_WSTRB   = s;
    bus_if.S_AXI_AWVALID = 1'b1;
    bus_if.S_AXI_WVALID  = 1'b1;
    @(negedge clk);
    n = 1;
    cs_n = 0;
    chk({tag, "_awready"}, 32'(bus_if.S_AXI_AWREADY), 32'd1);
    chk({tag, "_wready"}, 32'(bus_if.S_AXI_WREADY), 32'd1);
    bus_if.S_AXI_AWVALID = 1'b0;
    bus_if.S_AXI_WVALID  = 1'b0;
    while (!bus_if.S_AXI_BVALID && n < 40) begin
      if (bus_if.Bus2IP_CS) cs_n++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_cs_cycles"}, 32'(cs_n), 32'(exp_cs));
    chk({tag, "_bresp"}, 32'(bus_if.S_AXI_BRESP), 32'(exp_r));
    bus_if.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    chk({tag, "_bvalid_clr"}, 32'(bus_if.S_AXI_BVALID), 32'd0);
    bus_if.S_AXI_BREADY = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  logic [3:0] order;
  int         w;

  initial begin
    rom[0] = 32'h4E463130;
    rom[1] = 32'h00010000;
    rom[2] = 32'hCAFE0002;
    rom[3] = 32'h0000BEEF;
    bus_if.S_AXI_AWADDR  = '0;
    bus_if.S_AXI_AWVALID = 1'b0;
    bus_if.S_AXI_WDATA   = '0;
    bus_if.S_AXI_WSTRB   = '0;
    bus_if.S_AXI_WVALID  = 1'b0;
    bus_if.S_AXI_BREADY  = 1'b0;
    bus_if.S_AXI_ARADDR  = '0;
    bus_if.S_AXI_ARVALID = 1'b0;
    bus_if.S_AXI_RREADY  = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_resetn", 32'(bus_if.Bus2IP_Resetn), 32'd0);
    chk("rst_arready", 32'(bus_if.S_AXI_ARREADY), 32'd0);
    chk("rst_awready", 32'(bus_if.S_AXI_AWREADY), 32'd0);
    chk("rst_wready", 32'(bus_if.S_AXI_WREADY), 32'd0);
    chk("rst_rvalid", 32'(bus_if.S_AXI_RVALID), 32'd0);
    chk("rst_bvalid", 32'(bus_if.S_AXI_BVALID), 32'd0);
    chk("rst_rdata", bus_if.S_AXI_RDATA, 32'd0);
    chk("rst_rresp", 32'(bus_if.S_AXI_RRESP), 32'd0);
    chk("rst_bresp", 32'(bus_if.S_AXI_BRESP), 32'd0);
    chk("rst_cs", 32'(bus_if.Bus2IP_CS), 32'd0);
    chk("rst_rnw", 32'(bus_if.Bus2IP_RNW), 32'd1);
    chk("rst_addr", bus_if.Bus2IP_Addr, 32'd0);
    chk("rst_data", bus_if.Bus2IP_Data, 32'd0);
    chk("rst_be", 32'(bus_if.Bus2IP_BE), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_resetn", 32'(bus_if.Bus2IP_Resetn), 32'd1);

    // in-BAR read / write with a single-cycle-ack slave
    do_read("t1_rd", 32'h7A000008, 32'hCAFE0002, 2'b00, 3, 2);
    chk("t1_addr", bus_if.Bus2IP_Addr, 32'h7A000008);
    chk("t1_rnw", 32'(bus_if.Bus2IP_RNW), 32'd1);
    do_write("t2_wr", 32'h7A000004, 32'h12345678, 4'b0011, 2'b00, 3, 2);
    chk("t2_data", cap_data, 32'h12345678);
    chk("t2_be", 32'(cap_be), 32'h3);
    chk("t2_addr", cap_addr, 32'h7A000004);

    // outside the BAR and BAR edges
    do_read("t3_rd_out", 32'h7B000000, 32'h0, 2'b11, 2, 0);
    do_write("t3_wr_out", 32'h7B000000, 32'hDEADBEEF, 4'hF, 2'b11, 2, 0);
    do_read("t3_rd_hi", 32'h7A00FFFF, 32'h0000BEEF, 2'b00, 3, 2);
    do_read("t3_rd_lo", 32'h7A000000, 32'h4E463130, 2'b00, 3, 2);
    do_read("t3_rd_below", 32'h79FFFFFF, 32'h0, 2'b11, 2, 0);
    do_read("t3_rd_above", 32'h7A010000, 32'h0, 2'b11, 2, 0);

    // timeout and error ack
    slave_mode = 1;
    do_read("t4_rd_to", 32'h7A000008, 32'h0, 2'b10, 9, 8);
    do_write("t4_wr_to", 32'h7A000004, 32'h0000AAAA, 4'hF, 2'b10, 9, 8);
    slave_mode = 2;
    do_read("t4_rd_err", 32'h7A000008, 32'hCAFE0002, 2'b10, 3, 2);
    do_write("t4_wr_err", 32'h7A000004, 32'h0000BBBB, 4'hF, 2'b10, 3, 2);
    slave_mode = 0;

    // reset during a read data phase
    slave_mode = 1;
    bus_if.S_AXI_ARADDR  = 32'h7A000000;
    bus_if.S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    chk("t6_cs_on", 32'(bus_if.Bus2IP_CS), 32'd1);
    chk("t6_state_ph", 32'(dbg_state), 32'd1);
    bus_if.S_AXI_ARVALID = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_cs_off", 32'(bus_if.Bus2IP_CS), 32'd0);
    chk("t6_rvalid", 32'(bus_if.S_AXI_RVALID), 32'd0);
    chk("t6_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    slave_mode = 0;
    @(negedge clk);
    do_read("t6_rd_after", 32'h7A000008, 32'hCAFE0002, 2'b00, 3, 2);

    // round-robin with both request types pending
    pulse_reset();
    order = 4'h0;
    bus_if.S_AXI_ARADDR  = 32'h7A000008;
    bus_if.S_AXI_AWADDR  = 32'h7A000000;
    bus_if.S_AXI_WDATA   = 32'h00C0FFEE;
    bus_if.S_AXI_WSTRB   = 4'hF;
    bus_if.S_AXI_ARVALID = 1'b1;
    bus_if.S_AXI_AWVALID = 1'b1;
    bus_if.S_AXI_WVALID  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = 0;
      @(negedge clk);
      while (!bus_if.S_AXI_ARREADY && !bus_if.S_AXI_AWREADY && w < 10) begin
        @(negedge clk);
        w++;
      end
      if (bus_if.S_AXI_ARREADY) begin
        order[i] = 1'b0;
        bus_if.S_AXI_ARVALID = 1'b0;
        w = 0;
        while (!bus_if.S_AXI_RVALID && w < 20) begin
          @(negedge clk);
          w++;
        end
        chk("t5_rr_rdata", bus_if.S_AXI_RDATA, 32'hCAFE0002);
        bus_if.S_AXI_RREADY  = 1'b1;
        bus_if.S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        bus_if.S_AXI_RREADY  = 1'b0;
      end else if (bus_if.S_AXI_AWREADY) begin
        order[i] = 1'b1;
        bus_if.S_AXI_AWVALID = 1'b0;
        bus_if.S_AXI_WVALID  = 1'b0;
        w = 0;
        while (!bus_if.S_AXI_BVALID && w < 20) begin
          @(negedge clk);
          w++;
        end
        chk("t5_rr_bresp", 32'(bus_if.S_AXI_BRESP), 32'd0);
        bus_if.S_AXI_BREADY  = 1'b1;
        bus_if.S_AXI_AWVALID = 1'b1;
        bus_if.S_AXI_WVALID  = 1'b1;
        @(negedge clk);
        bus_if.S_AXI_BREADY  = 1'b0;
      end else begin
        chk("t5_rr_accept", 32'd0, 32'd1);
      end
    end
    bus_if.S_AXI_ARVALID = 1'b0;
    bus_if.S_AXI_AWVALID = 1'b0;
    bus_if.S_AXI_WVALID  = 1'b0;
    chk("t5_rr_order", 32'(order), 32'hA);
    @(negedge clk);

    // response back-pressure with a second read already requested
    bus_if.S_AXI_ARADDR  = 32'h7A000008;
    bus_if.S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    chk("t5_st_arready", 32'(bus_if.S_AXI_ARREADY), 32'd1);
    bus_if.S_AXI_ARADDR = 32'h7A00000C;
    w = 0;
    while (!bus_if.S_AXI_RVALID && w < 20) begin
      @(negedge clk);
      w++;
    end
    for (int k = 0; k < 5; k++) begin
      chk("t5_st_rvalid", 32'(bus_if.S_AXI_RVALID), 32'd1);
      chk("t5_st_rdata", bus_if.S_AXI_RDATA, 32'hCAFE0002);
      chk("t5_st_rresp", 32'(bus_if.S_AXI_RRESP), 32'd0);
      chk("t5_st_no_arready", 32'(bus_if.S_AXI_ARREADY), 32'd0);
      @(negedge clk);
    end
    bus_if.S_AXI_RREADY = 1'b1;
    @(negedge clk);
    bus_if.S_AXI_RREADY = 1'b0;
    chk("t5_st_rvalid_clr", 32'(bus_if.S_AXI_RVALID), 32'd0);
    @(negedge clk);
    chk("t5_st_next_arready", 32'(bus_if.S_AXI_ARREADY), 32'd1);
    bus_if.S_AXI_ARVALID = 1'b0;
    w = 0;
    while (!bus_if.S_AXI_RVALID && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("t5_st_next_rdata", bus_if.S_AXI_RDATA, 32'h0000BEEF);
    bus_if.S_AXI_RREADY = 1'b1;
    @(negedge clk);
    bus_if.S_AXI_RREADY = 1'b0;
    @(negedge clk);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
